// File: rtl/scratchpad_request_arbiter_pkg.sv
// Shared types for the scratchpad request arbiter: lane geometry, request record
// and arbiter FSM states.
package scratchpad_request_arbiter_pkg;

    localparam int SM_PE                 = 2;
    localparam int SM_ADDR_W             = 16;
    localparam int SM_DATA_W             = 32;
    localparam int SM_PIGGYBACK_DATA_LEN = 8;

    typedef logic [SM_ADDR_W-1:0]             sm_address_t;
    typedef logic [SM_DATA_W-1:0]             sm_data_t;
    typedef logic [SM_DATA_W/8-1:0]           sm_byte_mask_t;
    typedef logic [SM_PIGGYBACK_DATA_LEN-1:0] sm_piggyback_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } spm_arb_state_t;

    typedef struct packed {
        logic                           is_store;
        sm_address_t   [SM_PE-1:0]      addresses;
        sm_data_t      [SM_PE-1:0]      write_data;
        sm_byte_mask_t [SM_PE-1:0]      byte_mask;
        logic          [SM_PE-1:0]      pending_mask;
        sm_piggyback_t                  piggyback;
    } spm_request_t;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/scratchpad_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    int unsigned idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the block can leave a value held and infer a latch.
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/scratchpad_request_arbiter.sv
// Round-robin sharing of one scratchpad port among NUM_REQ requesters, with a one-entry
// hold register, per-requester outstanding counters and response demux by piggyback id.
module scratchpad_request_arbiter
    import scratchpad_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int USER_LEN = SM_PIGGYBACK_DATA_LEN - ID_W,
    parameter int MAX_OUT  = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic          [NUM_REQ-1:0]            req_valid,
    output logic          [NUM_REQ-1:0]            req_ready,
    input  logic          [NUM_REQ-1:0]            req_is_store,
    input  sm_address_t   [NUM_REQ-1:0][SM_PE-1:0] req_addresses,
    input  sm_data_t      [NUM_REQ-1:0][SM_PE-1:0] req_write_data,
    input  sm_byte_mask_t [NUM_REQ-1:0][SM_PE-1:0] req_byte_mask,
    input  logic          [NUM_REQ-1:0][SM_PE-1:0] req_pending_mask,
    input  logic          [NUM_REQ-1:0][USER_LEN-1:0] req_user,
    output logic                                   spm_is_store,
    output sm_address_t   [SM_PE-1:0]              spm_addresses,
    output sm_data_t      [SM_PE-1:0]              spm_write_data,
    output sm_byte_mask_t [SM_PE-1:0]              spm_byte_mask,
    output logic          [SM_PE-1:0]              spm_pending_mask,
    output sm_piggyback_t                          spm_piggyback_data,
    input  logic                                   spm_ready,
    input  logic                                   spm_rsp_valid,
    input  sm_piggyback_t                          spm_rsp_piggyback,
    output logic          [NUM_REQ-1:0]            rsp_valid,
    output logic          [USER_LEN-1:0]           rsp_user,
    output logic          [NUM_REQ-1:0]            busy
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    spm_arb_state_t     state, state_next;
    spm_request_t       hold, picked;
    logic [ID_W-1:0]    rr_ptr, ptr_next;
    cnt_t               cnt      [NUM_REQ];
    cnt_t               cnt_next [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_winner;
    logic               arb_found;
    logic               accept;

    logic [ID_W-1:0]    rsp_id;
    logic               rsp_fire;
    logic [NUM_REQ-1:0] rsp_dec;
    logic [NUM_REQ-1:0] busy_next;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt[i] < cnt_t'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (arb_grant),
        .winner   (arb_winner),
        .found    (arb_found)
    );

    // A new request may enter when the slot is free or is being drained this cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            EMPTY: begin
                if (arb_found) begin
                    accept     = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (spm_ready) begin
                    if (arb_found) begin
                        accept = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
        req_ready = accept ? arb_grant : '0;
    end

    always_comb begin
        picked.is_store     = req_is_store[arb_winner];
        picked.addresses    = req_addresses[arb_winner];
        picked.write_data   = req_write_data[arb_winner];
        picked.byte_mask    = req_byte_mask[arb_winner];
        picked.pending_mask = req_pending_mask[arb_winner];
        picked.piggyback    = {arb_winner, req_user[arb_winner]};
        ptr_next            = ID_W'(ring_next(int'(arb_winner), NUM_REQ));
    end

    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            state  <= EMPTY;
            rr_ptr <= '0;
            // NOTE: the hold register is reset (unlike a RAM) because it drives the
            // scratchpad port directly and must present zeros after reset.
            hold   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                hold   <= picked;
                rr_ptr <= ptr_next;
            end else if (state == FULL && spm_ready) begin
                hold.pending_mask <= '0;
            end
        end
    end

    assign spm_is_store       = hold.is_store;
    assign spm_addresses      = hold.addresses;
    assign spm_write_data     = hold.write_data;
    assign spm_byte_mask      = hold.byte_mask;
    assign spm_pending_mask   = hold.pending_mask;
    assign spm_piggyback_data = hold.piggyback;

    // Responses carrying an id outside the requester range are dropped.
    assign rsp_id   = spm_rsp_piggyback[SM_PIGGYBACK_DATA_LEN-1 -: ID_W];
    assign rsp_fire = spm_rsp_valid && (int'(rsp_id) < NUM_REQ);

    always_comb begin
        rsp_dec   = '0;
        busy_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_dec[i]  = rsp_fire && (rsp_id == ID_W'(i));
            cnt_next[i] = cnt[i];
            if (req_ready[i] && !rsp_dec[i]) begin
                cnt_next[i] = cnt[i] + cnt_t'(1);
            end else if (!req_ready[i] && rsp_dec[i] && cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - cnt_t'(1);
            end
            busy_next[i] = (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '{default: '0};
            busy      <= '0;
            rsp_valid <= '0;
            rsp_user  <= '0;
        end else begin
            cnt       <= cnt_next;
            busy      <= busy_next;
            rsp_valid <= rsp_fire ? (NUM_REQ'(1) << rsp_id) : '0;
            if (rsp_fire) begin
                rsp_user <= spm_rsp_piggyback[USER_LEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_request_arbiter.sv
// Directed bench for scratchpad_request_arbiter: stimulus pushes expected grants, scratchpad
// transfers and responses into queues; a negedge monitor pops and compares them.
module tb_scratchpad_request_arbiter;
    import scratchpad_request_arbiter_pkg::*;

    localparam int NUM_REQ  = 2;
    localparam int ID_W     = 1;
    localparam int USER_LEN = SM_PIGGYBACK_DATA_LEN - ID_W;
    localparam int MAX_OUT  = 4;

    logic                                   clock = 1'b0;
    logic                                   reset;
    logic          [NUM_REQ-1:0]            req_valid;
    logic          [NUM_REQ-1:0]            req_ready;
    logic          [NUM_REQ-1:0]            req_is_store;
    sm_address_t   [NUM_REQ-1:0][SM_PE-1:0] req_addresses;
    sm_data_t      [NUM_REQ-1:0][SM_PE-1:0] req_write_data;
    sm_byte_mask_t [NUM_REQ-1:0][SM_PE-1:0] req_byte_mask;
    logic          [NUM_REQ-1:0][SM_PE-1:0] req_pending_mask;
    logic          [NUM_REQ-1:0][USER_LEN-1:0] req_user;
    logic                                   spm_is_store;
    sm_address_t   [SM_PE-1:0]              spm_addresses;
    sm_data_t      [SM_PE-1:0]              spm_write_data;
    sm_byte_mask_t [SM_PE-1:0]              spm_byte_mask;
    logic          [SM_PE-1:0]              spm_pending_mask;
    sm_piggyback_t                          spm_piggyback_data;
    logic                                   spm_ready;
    logic                                   spm_rsp_valid;
    sm_piggyback_t                          spm_rsp_piggyback;
    logic          [NUM_REQ-1:0]            rsp_valid;
    logic          [USER_LEN-1:0]           rsp_user;
    logic          [NUM_REQ-1:0]            busy;

    scratchpad_request_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .USER_LEN (USER_LEN),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_is_store       (req_is_store),
        .req_addresses      (req_addresses),
        .req_write_data     (req_write_data),
        .req_byte_mask      (req_byte_mask),
        .req_pending_mask   (req_pending_mask),
        .req_user           (req_user),
        .spm_is_store       (spm_is_store),
        .spm_addresses      (spm_addresses),
        .spm_write_data     (spm_write_data),
        .spm_byte_mask      (spm_byte_mask),
        .spm_pending_mask   (spm_pending_mask),
        .spm_piggyback_data (spm_piggyback_data),
        .spm_ready          (spm_ready),
        .spm_rsp_valid      (spm_rsp_valid),
        .spm_rsp_piggyback  (spm_rsp_piggyback),
        .rsp_valid          (rsp_valid),
        .rsp_user           (rsp_user),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic                  is_store;
        sm_address_t           addr0;
        sm_address_t           addr1;
        sm_data_t              wdata0;
        logic [SM_PE-1:0]      pending;
        sm_piggyback_t         pb;
    } spm_exp_t;

    typedef struct packed {
        logic [NUM_REQ-1:0]    valid;
        logic [USER_LEN-1:0]   user;
    } rsp_exp_t;

    int        grant_q[$];
    spm_exp_t  spm_q[$];
    rsp_exp_t  rsp_q[$];
    int        checks = 0;
    int        errors = 0;

    // What each requester is currently driving, kept by the bench for building expectations.
    sm_address_t         tb_addr  [NUM_REQ];
    logic [USER_LEN-1:0] tb_user  [NUM_REQ];
    logic                tb_store [NUM_REQ];
    logic [SM_PE-1:0]    tb_pend  [NUM_REQ];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input sm_address_t addr, input logic [USER_LEN-1:0] user,
                           input logic store, input logic [SM_PE-1:0] pend);
        tb_addr[i]             = addr;
        tb_user[i]             = user;
        tb_store[i]            = store;
        tb_pend[i]             = pend;
        req_addresses[i][0]    = addr;
        req_addresses[i][1]    = addr + 16'd4;
        req_write_data[i][0]   = {16'hDA7A, addr};
        req_write_data[i][1]   = ~{16'hDA7A, addr};
        req_byte_mask[i][0]    = 4'hF;
        req_byte_mask[i][1]    = 4'hF;
        req_pending_mask[i]    = pend;
        req_user[i]            = user;
        req_is_store[i]        = store;
        req_valid[i]           = 1'b1;
    endtask

    task automatic expect_grant(input int i);
        spm_exp_t e;
        e.is_store = tb_store[i];
        e.addr0    = tb_addr[i];
        e.addr1    = tb_addr[i] + 16'd4;
        e.wdata0   = {16'hDA7A, tb_addr[i]};
        e.pending  = tb_pend[i];
        e.pb       = {ID_W'(i), tb_user[i]};
        grant_q.push_back(i);
        spm_q.push_back(e);
    endtask

    task automatic send_rsp(input int id, input logic [USER_LEN-1:0] user);
        rsp_exp_t r;
        r.valid = NUM_REQ'(1) << id;
        r.user  = user;
        rsp_q.push_back(r);
        spm_rsp_valid     = 1'b1;
        spm_rsp_piggyback = {ID_W'(id), user};
    endtask

    int       mon_grant;
    spm_exp_t mon_spm;
    rsp_exp_t mon_rsp;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: requester %0d granted, none expected", i);
                    end else begin
                        mon_grant = grant_q.pop_front();
                        check("grant_id", 64'(i), 64'(mon_grant));
                    end
                end
            end
            if (spm_pending_mask != '0 && spm_ready) begin
                if (spm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_spm_transfer: addr0 0x%0h", spm_addresses[0]);
                end else begin
                    mon_spm = spm_q.pop_front();
                    check("spm_is_store", 64'(spm_is_store), 64'(mon_spm.is_store));
                    check("spm_addr0", 64'(spm_addresses[0]), 64'(mon_spm.addr0));
                    check("spm_addr1", 64'(spm_addresses[1]), 64'(mon_spm.addr1));
                    check("spm_wdata0", 64'(spm_write_data[0]), 64'(mon_spm.wdata0));
                    check("spm_pending", 64'(spm_pending_mask), 64'(mon_spm.pending));
                    check("spm_piggyback", 64'(spm_piggyback_data), 64'(mon_spm.pb));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid 0x%0h", rsp_valid);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(mon_rsp.valid));
                    check("rsp_user", 64'(rsp_user), 64'(mon_rsp.user));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        req_valid         = '0;
        req_is_store      = '0;
        req_addresses     = '0;
        req_write_data    = '0;
        req_byte_mask     = '0;
        req_pending_mask  = '0;
        req_user          = '0;
        spm_ready         = 1'b0;
        spm_rsp_valid     = 1'b0;
        spm_rsp_piggyback = '0;
        step();
        step();

        // Reset state
        check("rst_pending", 64'(spm_pending_mask), 64'h0);
        check("rst_piggyback", 64'(spm_piggyback_data), 64'h0);
        check("rst_addr0", 64'(spm_addresses[0]), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_user", 64'(rsp_user), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        step();

        // Single request from requester 0
        set_req(0, 16'h0010, 7'h11, 1'b0, 2'b11);
        expect_grant(0);
        #1 check("t1_req_ready", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        check("t1_pending", 64'(spm_pending_mask), 64'h3);
        check("t1_piggyback", 64'(spm_piggyback_data), 64'h11);
        spm_ready = 1'b1;
        step();
        spm_ready = 1'b0;
        check("t1_empty", 64'(spm_pending_mask), 64'h0);
        check("t1_busy", 64'(busy), 64'h1);
        send_rsp(0, 7'h11);
        step();
        spm_rsp_valid = 1'b0;
        check("t1_busy_clear", 64'(busy), 64'h0);

        // Contention: pointer sits at 1 after the first grant, so grants go 1,0,1,0
        set_req(0, 16'h0100, 7'h01, 1'b0, 2'b11);
        set_req(1, 16'h0200, 7'h02, 1'b1, 2'b01);
        spm_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_grant((k % 2 == 0) ? 1 : 0);
            step();
        end
        req_valid = '0;
        step();
        spm_ready = 1'b0;
        check("t2_busy", 64'(busy), 64'h3);
        send_rsp(1, 7'h2A);
        step();
        send_rsp(1, 7'h02);
        step();
        send_rsp(0, 7'h01);
        step();
        send_rsp(0, 7'h01);
        step();
        spm_rsp_valid = 1'b0;
        check("t2_busy_clear", 64'(busy), 64'h0);

        // Backpressure for five cycles, then release with a waiting requester
        set_req(0, 16'h0300, 7'h03, 1'b0, 2'b11);
        expect_grant(0);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 16'h0400, 7'h04, 1'b1, 2'b10);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_req_ready", 64'(req_ready), 64'h0);
            check("t3_addr0", 64'(spm_addresses[0]), 64'h0300);
            check("t3_piggyback", 64'(spm_piggyback_data), 64'h03);
            step();
        end
        spm_ready = 1'b1;
        expect_grant(1);
        #1 check("t3_release", 64'(req_ready), 64'h2);
        step();
        req_valid[1] = 1'b0;
        step();
        spm_ready = 1'b0;
        send_rsp(0, 7'h03);
        step();
        send_rsp(1, 7'h04);
        step();
        spm_rsp_valid = 1'b0;

        // Outstanding limit on requester 0; requester 1 keeps going
        spm_ready = 1'b1;
        set_req(0, 16'h0500, 7'h05, 1'b0, 2'b11);
        for (int k = 0; k < 4; k++) begin
            expect_grant(0);
            step();
        end
        set_req(1, 16'h0600, 7'h06, 1'b1, 2'b11);
        expect_grant(1);
        #1 check("t4_block", 64'(req_ready), 64'h2);
        step();
        req_valid[1] = 1'b0;
        send_rsp(0, 7'h05);
        #1 check("t4_still_blocked", 64'(req_ready), 64'h0);
        step();
        spm_rsp_valid = 1'b0;
        expect_grant(0);
        #1 check("t4_regrant", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        step();
        spm_ready = 1'b0;

        // Response demux and same-cycle grant plus response on requester 1
        set_req(1, 16'h0700, 7'h07, 1'b0, 2'b01);
        expect_grant(1);
        send_rsp(1, 7'h2A);
        #1 check("t5_grant", 64'(req_ready), 64'h2);
        step();
        req_valid[1]  = 1'b0;
        spm_rsp_valid = 1'b0;
        check("t5_busy_held", 64'(busy), 64'h3);
        spm_ready = 1'b1;
        step();
        spm_ready = 1'b0;
        send_rsp(1, 7'h55);
        step();
        spm_rsp_valid = 1'b0;
        check("t5_busy_after", 64'(busy), 64'h1);

        // Reset while FULL with counters {2,1}
        for (int k = 0; k < 3; k++) begin
            send_rsp(0, 7'h05);
            step();
        end
        spm_rsp_valid = 1'b0;
        spm_ready = 1'b1;
        set_req(1, 16'h0800, 7'h08, 1'b1, 2'b11);
        expect_grant(1);
        step();
        req_valid[1] = 1'b0;
        set_req(0, 16'h0900, 7'h09, 1'b0, 2'b11);
        expect_grant(0);
        step();
        req_valid[0] = 1'b0;
        spm_ready = 1'b0;
        check("t6_busy_before", 64'(busy), 64'h3);
        check("t6_full_before", 64'(spm_pending_mask), 64'h3);
        reset = 1'b1;
        void'(spm_q.pop_back());
        step();
        reset = 1'b0;
        check("t6_pending", 64'(spm_pending_mask), 64'h0);
        check("t6_addr0", 64'(spm_addresses[0]), 64'h0);
        check("t6_busy", 64'(busy), 64'h0);
        check("t6_rsp_valid", 64'(rsp_valid), 64'h0);
        set_req(0, 16'h0A00, 7'h0A, 1'b0, 2'b11);
        set_req(1, 16'h0B00, 7'h0B, 1'b1, 2'b11);
        expect_grant(0);
        #1 check("t6_rr_ptr", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        spm_ready = 1'b1;
        step();
        spm_ready = 1'b0;
        check("t6_busy_one", 64'(busy), 64'h1);
        send_rsp(0, 7'h0A);
        step();
        spm_rsp_valid = 1'b0;
        step();
        check("t6_busy_clear", 64'(busy), 64'h0);

        step();
        step();
        check("grant_q_drained", 64'(grant_q.size()), 64'h0);
        check("spm_q_drained", 64'(spm_q.size()), 64'h0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
